// File: rtl/im_pkg.sv
// im_pkg: shared constants and types for the image-memory responder.
//   ADDR_W / DATA_W / DEPTH / FB_WORDS : default geometry of the image memory
//   HDR_*                              : word offsets of the preload header
//   state_t                            : responder phase (host preload, then serve)
package im_pkg;

  localparam int ADDR_W   = 20;
  localparam int DATA_W   = 24;
  localparam int DEPTH    = 65536;
  localparam int FB_WORDS = 16384;   // one 128x128 frame

  // Header layout written by the host at the start of the preload stream.
  localparam int HDR_INIT_TIME = 0;
  localparam int HDR_FB_ADDR   = 1;  // frame-buffer base, snooped during preload
  localparam int HDR_PHOTO_NUM = 2;
  localparam int HDR_P1_ADDR   = 3;
  localparam int HDR_P1_SIZE   = 4;
  localparam int HDR_P2_ADDR   = 5;
  localparam int HDR_P2_SIZE   = 6;
  localparam int HDR_P3_ADDR   = 7;
  localparam int HDR_P3_SIZE   = 8;
  localparam int HDR_P4_ADDR   = 9;
  localparam int HDR_P4_SIZE   = 10;

  typedef enum logic {
    LOAD  = 1'b0,
    SERVE = 1'b1
  } state_t;

endpackage

// File: rtl/im_if.sv
// im_if: image-memory bus plus host preload stream.
//   IM_A / IM_D / IM_WEN : initiator request (IM_WEN 1 = read, 0 = write)
//   IM_Q                 : read data, one cycle after the read request
//   load_valid / load_ready / load_addr / load_data / load_done : host preload
// master = initiator/host side, slave = responder side.
interface im_if #(
  parameter int ADDR_W = im_pkg::ADDR_W,
  parameter int DATA_W = im_pkg::DATA_W
);

  logic [ADDR_W-1:0] IM_A;
  logic [DATA_W-1:0] IM_D;
  logic              IM_WEN;
  logic [DATA_W-1:0] IM_Q;

  logic              load_valid;
  logic              load_ready;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic              load_done;

  modport master (
    output IM_A, IM_D, IM_WEN, load_valid, load_addr, load_data, load_done,
    input  IM_Q, load_ready
  );

  modport slave (
    input  IM_A, IM_D, IM_WEN, load_valid, load_addr, load_data, load_done,
    output IM_Q, load_ready
  );

endinterface

// File: rtl/im_sram.sv
// im_sram: single-port synchronous RAM, DEPTH x DATA_W.
//   clk   : clock
//   en    : access enable
//   we    : 1 = write wdata to addr, 0 = read addr into q
//   addr  : word address
//   wdata : write data
//   q     : registered read data; holds on write or idle cycles
module im_sram #(
  parameter int DEPTH  = 65536,
  parameter int DATA_W = 24,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the array and its read register have no reset so they map onto
  // block RAM; contents survive a system reset by design.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    q         <= mem[addr];
    end
  end

endmodule

// File: rtl/im_responder.sv
// im_responder: target end of the image-memory interface.
//   clk        : system clock
//   reset      : asynchronous active-low reset
//   bus        : im_if.slave (IM request/response + host preload stream)
//   im_ready   : high while serving initiator accesses
//   frame_done : 1-cycle pulse after the last write of a frame
//   frame_cnt  : completed frames, wraps at 16 bits
//   oor_err    : sticky out-of-range access flag
// The host preloads memory first (LOAD); after load_done the initiator owns
// the RAM port for good (SERVE) until the next reset.
module im_responder #(
  parameter int ADDR_W   = im_pkg::ADDR_W,
  parameter int DATA_W   = im_pkg::DATA_W,
  parameter int DEPTH    = im_pkg::DEPTH,
  parameter int FB_WORDS = im_pkg::FB_WORDS
) (
  input  logic  clk,
  input  logic  reset,
  im_if.slave   bus,
  output logic  im_ready,
  output logic  frame_done,
  output logic [15:0] frame_cnt,
  output logic  oor_err
);

  import im_pkg::*;

  localparam int AW    = $clog2(DEPTH);
  localparam int FBC_W = $clog2(FB_WORDS);

  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] FB_SPAN   = (ADDR_W+1)'(FB_WORDS);
  localparam logic [FBC_W-1:0] FB_LAST  = FBC_W'(FB_WORDS - 1);

  state_t            state, state_nx;
  logic              started;    // first edge after reset release has passed
  logic              q_zero;     // force IM_Q to 0 (reset, LOAD, out-of-range read)
  logic [ADDR_W-1:0] fb_base;
  logic [FBC_W-1:0]  fb_count;

  logic              serve, host_acc, im_in_rng, ld_in_rng, in_win, fb_hit, oor_hit;
  logic              ram_en, ram_we;
  logic [AW-1:0]     ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_q;

  assign serve          = (state == SERVE);
  assign im_ready       = serve;
  assign bus.load_ready = started && !serve;
  assign host_acc       = bus.load_ready && bus.load_valid;

  // Range and window compares carry one extra bit so fb_base+FB_WORDS cannot wrap.
  assign im_in_rng = {1'b0, bus.IM_A} < DEPTH_LIM;
  assign ld_in_rng = {1'b0, bus.load_addr} < DEPTH_LIM;
  assign in_win    = ({1'b0, bus.IM_A} >= {1'b0, fb_base}) &&
                     ({1'b0, bus.IM_A} <  ({1'b0, fb_base} + FB_SPAN));
  assign fb_hit    = serve && !bus.IM_WEN && in_win;
  assign oor_hit   = serve ? !im_in_rng : (host_acc && !ld_in_rng);

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    state_nx = state;
    if (!serve && bus.load_ready && bus.load_done) state_nx = SERVE;
  end

  // RAM port mux: host owns it in LOAD, initiator in SERVE.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = bus.load_addr[AW-1:0];
    ram_wdata = bus.load_data;
    if (serve) begin
      ram_en    = im_in_rng;
      ram_we    = !bus.IM_WEN;
      ram_addr  = bus.IM_A[AW-1:0];
      ram_wdata = bus.IM_D;
    end else begin
      ram_en    = host_acc && ld_in_rng;
      ram_we    = 1'b1;
    end
  end

  im_sram #(.DEPTH(DEPTH), .DATA_W(DATA_W), .AW(AW)) u_sram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .q     (ram_q)
  );

  // The RAM read register is not reset, so IM_Q is qualified here instead.
  assign bus.IM_Q = q_zero ? '0 : ram_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= LOAD;
      started    <= 1'b0;
      q_zero     <= 1'b1;
      fb_base    <= '0;
      fb_count   <= '0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
      oor_err    <= 1'b0;
    end else begin
      state      <= state_nx;
      started    <= 1'b1;
      frame_done <= 1'b0;
      if (oor_hit) oor_err <= 1'b1;
      if (serve && bus.IM_WEN) q_zero <= !im_in_rng;
      if (host_acc && bus.load_addr == ADDR_W'(HDR_FB_ADDR))
        fb_base <= bus.load_data[ADDR_W-1:0];
      if (fb_hit) begin
        if (fb_count == FB_LAST) begin
          fb_count   <= '0;
          frame_done <= 1'b1;
          frame_cnt  <= frame_cnt + 16'd1;
        end else begin
          fb_count <= fb_count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_im_responder.sv
// tb_im_responder: randomized self-checking bench for im_responder.
// The reference model is a sparse word array plus a frame write counter.
module tb_im_responder;

  localparam int ADDR_W   = 20;
  localparam int DATA_W   = 24;
  localparam int DEPTH    = 65536;
  localparam int FB_WORDS = 16384;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        im_ready, frame_done, oor_err;
  logic [15:0] frame_cnt;

  im_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  im_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .FB_WORDS(FB_WORDS)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .im_ready   (im_ready),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt),
    .oor_err    (oor_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model
  logic [DATA_W-1:0] mem_m [int];
  int                addrs[$];
  bit                m_started, m_serve, m_oor, exp_done;
  int                m_base, m_fbn, m_frames;
  logic [DATA_W-1:0] m_q;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string ph);
    check({ph, ".IM_Q"},       32'(bus.IM_Q),       32'(m_q));
    check({ph, ".load_ready"}, 32'(bus.load_ready), 32'(m_started && !m_serve));
    check({ph, ".im_ready"},   32'(im_ready),       32'(m_serve));
    check({ph, ".frame_done"}, 32'(frame_done),     32'(exp_done));
    check({ph, ".frame_cnt"},  32'(frame_cnt),      32'(m_frames));
    check({ph, ".oor_err"},    32'(oor_err),        32'(m_oor));
  endtask

  task automatic mem_write(input int a, input logic [DATA_W-1:0] d);
    if (!mem_m.exists(a)) addrs.push_back(a);
    mem_m[a] = d;
  endtask

  // One clock cycle: drive every input, clock, then update the model and compare.
  task automatic step(input string ph, input logic lv, input int la, input logic [DATA_W-1:0] ld,
                      input logic done, input logic wen, input int a, input logic [DATA_W-1:0] d);
    bus.load_valid = lv;
    bus.load_addr  = ADDR_W'(la);
    bus.load_data  = ld;
    bus.load_done  = done;
    bus.IM_WEN     = wen;
    bus.IM_A       = ADDR_W'(a);
    bus.IM_D       = d;
    @(posedge clk);
    #1;
    exp_done = 1'b0;
    if (!m_serve) begin
      if (m_started && lv) begin
        if (la < DEPTH) mem_write(la, ld);
        else            m_oor = 1'b1;
        if (la == 1) m_base = int'(ld[ADDR_W-1:0]);
      end
      if (m_started && done) m_serve = 1'b1;
      m_started = 1'b1;
    end else begin
      if (a >= DEPTH) m_oor = 1'b1;
      if (wen) begin
        m_q = (a < DEPTH) ? mem_m[a] : '0;
      end else begin
        if (a < DEPTH) mem_write(a, d);
        if (a >= m_base && a < m_base + FB_WORDS) begin
          m_fbn++;
          if (m_fbn == FB_WORDS) begin
            m_fbn    = 0;
            exp_done = 1'b1;
            m_frames = (m_frames + 1) % 65536;
          end
        end
      end
    end
    check_outputs(ph);
  endtask

  task automatic srv_rd(input string ph, input int a);
    step(ph, 1'b0, 0, '0, 1'b0, 1'b1, a, '0);
  endtask

  task automatic srv_wr(input string ph, input int a, input logic [DATA_W-1:0] d);
    step(ph, 1'b0, 0, '0, 1'b0, 1'b0, a, d);
  endtask

  task automatic ld_wr(input string ph, input int la, input logic [DATA_W-1:0] ld, input logic done);
    step(ph, 1'b1, la, ld, done, 1'b1, 0, '0);
  endtask

  // Async reset asserted between edges; memory model is left intact.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_done  = 1'b0;
    bus.IM_WEN     = 1'b1;
    #1;
    m_started = 1'b0; m_serve = 1'b0; m_oor = 1'b0; exp_done = 1'b0;
    m_base = 0; m_fbn = 0; m_frames = 0; m_q = '0;
    check_outputs("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    check_outputs("reset_hold");
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int pulses;
    int a;
    bus.load_valid = 1'b0; bus.load_addr = '0; bus.load_data = '0; bus.load_done = 1'b0;
    bus.IM_WEN = 1'b1; bus.IM_A = '0; bus.IM_D = '0;

    do_reset();

    // Preload: header words, random photo words, an ignored IM write, done with a word.
    step("idle", 1'b0, 0, '0, 1'b0, 1'b1, 0, '0);
    ld_wr("pre0", 0, 24'h0C1E00, 1'b0);
    ld_wr("pre1", 1, 24'h002000, 1'b0);
    ld_wr("pre3", 3, 24'h003000, 1'b0);
    step("load_imwr", 1'b0, 0, '0, 1'b0, 1'b0, 3, 24'hFFFFFF);
    for (int i = 0; i < 20; i++)
      ld_wr("pre_rand", $urandom_range(16'h0100, 16'h1FFF), 24'($urandom), 1'b0);
    ld_wr("pre_done", 16'h0010, 24'h5A5A5A, 1'b1);
    check("fb_base_snoop", 32'(dut.fb_base), 32'h2000);

    // Directed reads.
    srv_rd("rd1", 1);
    check("rd1_value", 32'(bus.IM_Q), 32'h002000);
    srv_rd("rd0", 0);
    srv_rd("rd3", 3);
    check("rd3_value", 32'(bus.IM_Q), 32'h003000);
    srv_rd("rd_done_word", 16'h0010);

    // One full frame in the window.
    pulses = 0;
    for (int i = 0; i < FB_WORDS; i++) begin
      srv_wr("fill", 16'h2000 + i, 24'($urandom));
      if (frame_done) pulses++;
    end
    check("fill_frame_cnt", 32'(frame_cnt), 32'd1);
    check("fill_pulses", 32'(pulses), 32'd1);
    srv_wr("wr_above_win", 16'h6000, 24'h123456);
    check("fb_count_above", 32'(dut.fb_count), 32'd0);
    srv_wr("wr_below_win", 16'h1FFF, 24'h654321);
    check("fb_count_below", 32'(dut.fb_count), 32'd0);

    // Write then read back.
    srv_wr("wr2005", 16'h2005, 24'hABCDEF);
    srv_rd("rd2005", 16'h2005);
    check("rd2005_value", 32'(bus.IM_Q), 32'hABCDEF);
    srv_rd("rd_hold", 0);
    srv_wr("q_hold", 16'h0100, 24'h777777);

    // Random mix; load_* toggled too and must be ignored.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 1) a = addrs[$urandom_range(0, addrs.size() - 1)];
      else                           a = $urandom_range(0, DEPTH - 1);
      if ($urandom_range(0, 1) == 1 && mem_m.exists(a))
        step("rand_rd", 1'($urandom), 1, 24'($urandom), 1'($urandom), 1'b1, a, '0);
      else
        step("rand_wr", 1'($urandom), 1, 24'($urandom), 1'($urandom), 1'b0, a, 24'($urandom));
    end

    // Out-of-range accesses.
    srv_wr("oor_wr", 20'h10000, 24'h999999);
    check("oor_set", 32'(oor_err), 32'd1);
    srv_rd("oor_rd", 20'h10000);
    check("oor_rd_zero", 32'(bus.IM_Q), 32'd0);
    srv_rd("oor_alias0", 0);
    srv_rd("oor_rd3", 3);
    srv_rd("oor_max", 20'hFFFFF);
    check("oor_sticky", 32'(oor_err), 32'd1);

    // Reset mid-preload, then mid-LOAD again.
    do_reset();
    step("rl_idle", 1'b0, 0, '0, 1'b0, 1'b1, 0, '0);
    ld_wr("rl0", 16'h0200, 24'h111111, 1'b0);
    ld_wr("rl1", 16'h0201, 24'h222222, 1'b0);
    ld_wr("rl2", 16'h0202, 24'h333333, 1'b0);
    do_reset();
    step("rl_after", 1'b0, 0, '0, 1'b0, 1'b1, 0, '0);
    check("rl_load_ready", 32'(bus.load_ready), 32'd1);
    step("rl_imwr", 1'b0, 0, '0, 1'b0, 1'b0, 16'h0200, 24'hDEAD00);
    step("rl_imrd", 1'b0, 0, '0, 1'b0, 1'b1, 16'h0201, '0);
    check("rl_q_zero", 32'(bus.IM_Q), 32'd0);
    step("rl_done", 1'b0, 0, '0, 1'b1, 1'b1, 0, '0);
    srv_rd("rl_rd200", 16'h0200);
    check("rl_kept200", 32'(bus.IM_Q), 32'h111111);
    srv_rd("rl_rd201", 16'h0201);
    srv_rd("rl_rd202", 16'h0202);
    srv_rd("rl_rd1", 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/im_responder.md
Name: im_responder

Overview:
- Responder (target) end of the image-memory interface: services IM_A/IM_D/IM_WEN requests from the display-processing initiator and returns IM_Q with fixed 1-cycle read latency.
- Before serving, preloaded from a host stream (header, photos); snoops header word 1 (frame-buffer base).
- Counts frame-buffer writes and pulses frame_done per completed frame.
- Sits between the initiator and on-chip image SRAM; used in system sim and FPGA bring-up.

Parameters:
ADDR_W, 20, address width of IM_A / load_addr
DATA_W, 24, word width
DEPTH, 65536, implemented words; addresses >= DEPTH are out of range
FB_WORDS, 16384, words per frame (128x128)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
IM_A  in  ADDR_W  request address
IM_D  in  DATA_W  write data
IM_WEN  in  1  1 = read, 0 = write; one access every cycle while serving
IM_Q  out  DATA_W  read data, valid the cycle after a read
load_valid  in  1  host preload word valid
load_ready  out  1  responder accepts preload word
load_addr  in  ADDR_W  preload address
load_data  in  DATA_W  preload data
load_done  in  1  host finished preload (level or pulse)
im_ready  out  1  serving initiator accesses
frame_done  out  1  1-cycle pulse, frame fully written
frame_cnt  out  16  completed frames, wraps at 65535->0
oor_err  out  1  sticky out-of-range access flag

Behaviour:
- Reset (reset=0, async): state=LOAD, IM_Q=0, load_ready=0, im_ready=0, frame_done=0, frame_cnt=0, oor_err=0, fb_base=0, fb_count=0. Memory contents not cleared.
- Deassertion: load_ready=1 from the first clock edge after release.
- LOAD:
  - load_ready=1.
  - Each cycle with load_valid=1 writes mem[load_addr]=load_data.
  - load_addr==1 also updates fb_base = load_data[ADDR_W-1:0].
  - IM_A/IM_D/IM_WEN ignored, no writes; IM_Q held 0.
  - load_done=1 (with or without load_valid in the same cycle): the word in that cycle is still written, then next state=SERVE.
- SERVE:
  - load_ready=0, im_ready=1; load_* ignored; load_done has no further effect.
  - No return to LOAD except via reset.
- Read (IM_WEN=1): IM_Q at edge N+1 = mem[IM_A sampled at edge N]. IM_Q holds its value on write cycles.
- Write (IM_WEN=0): mem[IM_A]=IM_D at the edge. A read of the same address next cycle returns the new data (no bypass needed; accesses are sequential).
- Out of range (IM_A >= DEPTH or load_addr >= DEPTH):
  - Write dropped; read returns IM_Q=0.
  - oor_err set to 1 and held until reset.
- Frame tracking (SERVE writes only):
  - A write with fb_base <= IM_A < fb_base+FB_WORDS increments fb_count. Compare with ADDR_W+1-bit arithmetic; no wrap of the window.
  - When a qualifying write occurs with fb_count==FB_WORDS-1: fb_count=0, frame_done=1 for exactly the next cycle, frame_cnt+=1.
  - Writes outside the window, and all reads, do not count.
  - Rewrites of the same address count; no per-address tracking.
- Reset mid-LOAD or mid-frame:
  - Immediate return to reset values.
  - Memory keeps any words already written.
  - Host must re-preload.

Decomposition:
- Package im_pkg:
  - ADDR_W, DATA_W, FB_WORDS defaults.
  - Header offsets: HDR_INIT_TIME=0, HDR_FB_ADDR=1, HDR_PHOTO_NUM=2, HDR_P1_ADDR=3 .. HDR_P4_SIZE=10.
  - State enum {LOAD, SERVE}.
- One sub-module, im_sram: single-port synchronous RAM, DEPTH x DATA_W, registered read, write-enable.
  - im_responder muxes the host or initiator port onto it by state.

Test Plan:
- Reset, then preload addr0=0x0C1E00, addr1=0x002000, addr3=0x003000; pulse load_done -> im_ready=1 the cycle after load_done, load_ready=0, fb_base=0x2000.
- SERVE read IM_A=1 at edge N -> IM_Q=0x002000 at edge N+1; back-to-back reads of addr 0,3 -> 0x0C1E00, 0x003000 on consecutive cycles.
- Write IM_A=0x2005, IM_D=0xABCDEF, then read 0x2005 next cycle -> IM_Q=0xABCDEF one cycle later.
- Write 16384 consecutive words at 0x2000..0x5FFF -> frame_done single pulse after the last write, frame_cnt=1.
  - Write 0x6000 and 0x1FFF -> no count change.
- Write IM_A=0x10000 (DEPTH=65536) -> oor_err=1 and stays 1.
  - Read 0x10000 -> IM_Q=0.
  - Prior memory contents unchanged.
- Reset asserted during preload after 3 words -> all outputs back to reset values, state LOAD, load_ready=1 after release; IM requests ignored until a new load_done.
